// File: rtl/oh_to_uint_pipe_pkg.sv
// oh_to_uint_pipe_pkg: shared constants and width helper for the one-hot encoder pipe
package oh_to_uint_pipe_pkg;
  localparam int PRIO_OR = 0;
  localparam int PRIO_LOW = 1;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
  function automatic int out_w(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/oh_to_uint_pipe_if.sv
// oh_to_uint_pipe_if: input/output handshakes, clear and error count of the encoder pipe
interface oh_to_uint_pipe_if
  import oh_to_uint_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OUT_W = out_w(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_bits;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_bits;
  logic             out_zero;
  logic             out_multi;
  logic             clear;
  logic [CNT_W-1:0] err_count;
  modport master(
    output in_valid, in_bits, out_ready, clear,
    input  in_ready, out_valid, out_bits, out_zero, out_multi, err_count
  );
  modport slave(
    input  in_valid, in_bits, out_ready, clear,
    output in_ready, out_valid, out_bits, out_zero, out_multi, err_count
  );
endinterface

// File: rtl/oh_to_uint_pipe_stage.sv
// oh_pipe_stage: one elastic register slice; ready passes through combinationally when full
module oh_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  input  logic          ready_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);
  logic          valid_q;
  logic [DW-1:0] data_q;
  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  // load a new entry whenever the slot is empty or being drained
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end
endmodule

// File: rtl/oh_to_uint_pipe.sv
// oh_to_uint_pipe: elastic one-hot to binary encoder with malformed-input flags and error counter
module oh_to_uint_pipe
  import oh_to_uint_pipe_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2,
  parameter int PRIORITY    = PRIO_OR
) (
  input logic clk,
  input logic reset,
  oh_to_uint_pipe_if.slave io
);
  localparam int OUT_W = out_w(WIDTH);
  localparam int DW = OUT_W + 2;
  logic [OUT_W-1:0] idx_or, idx_low;
  logic             valid [PIPE_STAGES+1];
  logic             ready [PIPE_STAGES+1];
  logic [DW-1:0]    data  [PIPE_STAGES+1];
  logic [CNT_W-1:0] err_q, err_d;
  // both index modes from one scan; lowest-bit mode keeps the last hit scanning downwards
  always_comb begin
    idx_or  = '0;
    idx_low = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (io.in_bits[i]) begin
        idx_or  = idx_or | OUT_W'(i);
        idx_low = OUT_W'(i);
      end
    end
  end
  // payload is {zero, multi, index}; multi means clearing the lowest set bit leaves something
  assign valid[0] = io.in_valid;
  assign data[0]  = {io.in_bits == '0, |(io.in_bits & (io.in_bits - WIDTH'(1))),
                     PRIORITY == PRIO_LOW ? idx_low : idx_or};
  assign ready[PIPE_STAGES] = io.out_ready;
  assign io.in_ready = ready[0];
  for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
    oh_pipe_stage #(.DW(DW)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .valid_i(valid[g]),
      .data_i (data[g]),
      .ready_i(ready[g+1]),
      .ready_o(ready[g]),
      .valid_o(valid[g+1]),
      .data_o (data[g+1])
    );
  end
  assign io.out_valid = valid[PIPE_STAGES];
  assign {io.out_zero, io.out_multi, io.out_bits} = data[PIPE_STAGES];
  // clear beats increment; count only delivered malformed results, saturating
  always_comb
    err_d = io.clear ? '0 :
            (io.out_valid && io.out_ready && (io.out_zero || io.out_multi) && err_q != CNT_MAX)
              ? err_q + CNT_W'(1) : err_q;
  // error counter register
  always_ff @(posedge clk) begin
    if (reset) err_q <= '0;
    else err_q <= err_d;
  end
  assign io.err_count = err_q;
endmodule
